// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit.
//   XLEN / ILEN      : address and instruction widths
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : instruction queue entry {pc, instr}
//   word_align()     : clears the byte-offset bits of an address
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: small synchronous FIFO with a single-cycle flush.
// Parameters: DEPTH entries of WIDTH bits.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   flush            : empties the FIFO; wins over push/pop in the same cycle
//   push, push_data  : write an entry (accepted when not full, or full and popping)
//   pop              : drop the head entry (ignored when empty)
//   pop_data         : head entry, no read latency
//   count            : number of stored entries
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset so the exposed head word reads 0 out of reset
      // instead of X; flush only rewinds the pointers and leaves data as is.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit between the PC path and decode.
// Issues sequential word fetches over a req/gnt/rvalid memory interface,
// queues returned words with their pcs, and hands them to decode over a
// valid/ready handshake. A redirect flushes the queue, drops in-flight
// responses and restarts fetch at the redirect target.
// Parameters: DEPTH (2..4) queued + in-flight instructions, RESET_PC.
// Ports:
//   clk, rst                               : clock, async active-high reset
//   imem_req/imem_addr/imem_gnt            : fetch request channel
//   imem_rvalid/imem_rdata                 : in-order response channel
//   redirect_valid/redirect_pc             : flush and restart
//   if_valid/if_ready/if_instr/if_pc       : decode handshake
//   if_misaligned                          : misaligned redirect flag
// Build option: define IFETCH_MISALIGN_CHECK_EN to flag and halt on a
// redirect to a non-word-aligned target; otherwise the target is aligned
// and if_misaligned is tied 0.
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_misaligned
);

  localparam int CW = $clog2(DEPTH + 1);
  // Discards can pile up across back-to-back redirects, so give headroom.
  localparam int DW = CW + 3;

  logic [XLEN-1:0] fetch_pc;
  logic [DW-1:0]   discard;
  logic            halted;
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   outstanding;
  logic            pop;
  logic            grant;
  logic            rsp_any;
  logic            rsp_keep;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_target;
  logic            redirect_misaligned;
  fetch_entry_t    q_head;
  fetch_entry_t    q_push_data;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_target     = word_align(redirect_pc);
  assign redirect_misaligned = 1'b0;
`endif

  assign pop = if_valid && if_ready;

  // The slot freed by this cycle's pop is credited immediately so a
  // single-cycle memory sustains one instruction per cycle. With decode
  // stalled, issue stops exactly at queue count + outstanding = DEPTH.
  assign imem_req  = !rst && !redirect_valid && !halted &&
                     ((int'(q_count) + int'(outstanding) - int'(pop)) < DEPTH);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req && imem_gnt;

  // Responses come back in request order: the first `discard` of them belong
  // to requests issued before the last redirect. A response with nothing
  // pending at all is a protocol error and is simply ignored.
  assign rsp_any  = imem_rvalid && ((discard != '0) || (outstanding != '0));
  assign rsp_keep = imem_rvalid && (discard == '0) && (outstanding != '0);

  // The pc FIFO holds the address of every granted, unanswered request, so
  // its occupancy is the outstanding-request count.
  ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (grant),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .pop_data  (rsp_pc),
    .count     (outstanding)
  );

  assign q_push_data = '{pc: rsp_pc, instr: imem_rdata};

  // Flush has priority inside the FIFO, so a redirect also cancels any
  // push or pop requested in the same cycle.
  ifetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (q_push_data),
    .pop       (pop),
    .pop_data  (q_head),
    .count     (q_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      discard  <= '0;
      halted   <= 1'b0;
    end else if (redirect_valid) begin
      // No grant can land here because imem_req is held low this cycle.
      fetch_pc <= redirect_target;
      discard  <= discard + DW'(outstanding) - DW'(rsp_any);
      halted   <= redirect_misaligned;
    end else begin
      if (grant) fetch_pc <= fetch_pc + XLEN'(4);
      if (rsp_any && (discard != '0)) discard <= discard - DW'(1);
    end
  end

  assign if_valid      = (q_count != '0);
  assign if_pc         = q_head.pc;
  assign if_instr      = q_head.instr;
  assign if_misaligned = halted;

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch (DEPTH = 2).
// The reference model is architectural: after reset or a redirect to T,
// decode must receive T, T+4, T+8, ... with the memory word at each address,
// requests must walk the same sequence, and nothing stale may surface.
// The memory model grants and answers in order with a random latency.
module tb_inst_fetch;
  import ifetch_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = RESET_PC_DEFAULT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_misaligned;

  inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_misaligned  (if_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          gnt_pct = 100;
  int          rdy_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          force_gnt = 1'b0;
  bit          nop_mode = 1'b0;
  pend_t       pend[$];
  logic [31:0] exp_req_pc;
  logic [31:0] exp_pop_pc;
  bit          halted = 1'b0;
  bit          prev_redirect = 1'b0;
  bit          prev_req_pending = 1'b0;
  bit          grant_now = 1'b0;
  logic [31:0] grant_addr;
  int          grants = 0;
  int          req_seen = 0;
  int          total_pops = 0;
  int          first_req_cyc = -1;
  logic [31:0] first_req_addr = '0;
  logic [31:0] pop_pc_log[$];
  int          pop_cyc_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return nop_mode ? 32'h0000_0013 : (addr ^ 32'h5A5A_0013);
  endfunction

  // One clock cycle: drive inputs, sample at negedge+1, update the model.
  task automatic cycle(input bit rv, input logic [31:0] rpc);
    pend_t       item;
    bit          pop;
    logic [31:0] target;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if (pend.size() > 0 && pend[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
    end
    imem_gnt = force_gnt || ($urandom_range(99) < gnt_pct);
    if_ready = ($urandom_range(99) < rdy_pct);
    #1;
    if (rv) check("req_in_redirect", imem_req, 0);
    if (prev_redirect) check("valid_after_redirect", if_valid, 0);
    if (prev_redirect && !rv) check("req_after_redirect", imem_req, !halted);
    if (prev_req_pending && !rv) check("req_stable", imem_req, 1);
    if (halted) check("req_halted", imem_req, 0);
    check("misaligned_flag", if_misaligned, halted);
    if (imem_req) begin
      check("req_addr", imem_addr, exp_req_pc);
      req_seen++;
      if (first_req_cyc < 0) begin
        first_req_cyc  = cyc;
        first_req_addr = imem_addr;
      end
    end
    pop = if_valid && if_ready && !rv;
    if (pop) begin
      check("pop_pc", if_pc, exp_pop_pc);
      check("pop_instr", if_instr, mem_word(exp_pop_pc));
      pop_pc_log.push_back(if_pc);
      pop_cyc_log.push_back(cyc);
      exp_pop_pc += 32'd4;
      total_pops++;
    end
    grant_now = imem_req && imem_gnt;
    if (grant_now) begin
      item.addr  = imem_addr;
      item.ready = cyc + $urandom_range(lat_max, lat_min);
      pend.push_back(item);
      grant_addr = imem_addr;
      exp_req_pc += 32'd4;
      grants++;
    end
    if (imem_rvalid) begin
      assert (pend.size() > 0) else $error("response with no outstanding request");
      void'(pend.pop_front());
    end
    prev_req_pending = imem_req && !imem_gnt;
    if (rv) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
      target = rpc;
      halted = (rpc[1:0] != 2'b00);
`else
      target = {rpc[31:2], 2'b00};
      halted = 1'b0;
`endif
      exp_req_pc       = target;
      exp_pop_pc       = target;
      prev_req_pending = 1'b0;
    end
    prev_redirect = rv;
    @(posedge clk);
    @(negedge clk);
    redirect_valid = 1'b0;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  task automatic redir(input logic [31:0] pc);
    cycle(1'b1, pc);
  endtask

  // Waits (bounded) for the next delivered instruction and checks its pc.
  task automatic wait_pop(input string tag, input logic [31:0] exp);
    int n0;
    int k;
    n0 = pop_pc_log.size();
    k  = 0;
    while (pop_pc_log.size() == n0 && k < 50) begin
      cycle(1'b0, '0);
      k++;
    end
    if (pop_pc_log.size() == n0) check({tag, "_timeout"}, 0, 1);
    else check(tag, pop_pc_log[n0], exp);
  endtask

  // Asserts reset at a negedge, checks values immediately, releases at a negedge.
  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    if_ready       = 1'b0;
    #2;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", if_valid, 0);
    check("rst_instr", if_instr, 0);
    check("rst_pc", if_pc, 0);
    check("rst_misaligned", if_misaligned, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    pop_pc_log.delete();
    pop_cyc_log.delete();
    exp_req_pc       = RESET_PC;
    exp_pop_pc       = RESET_PC;
    halted           = 1'b0;
    prev_redirect    = 1'b0;
    prev_req_pending = 1'b0;
    first_req_cyc    = -1;
    cyc              = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int r0;
    bit found;
    @(negedge clk);

    // Reset and start: NOP memory, 1-cycle latency, decode always ready.
    nop_mode = 1'b1;
    do_reset();
    run(6);
    check("first_req_cycle", first_req_cyc, 0);
    check("first_req_addr", first_req_addr, 32'h0);
    check("start_pops", pop_pc_log.size() >= 3, 1);
    check("start_pc0", pop_pc_log[0], 32'h0);
    check("start_pc1", pop_pc_log[1], 32'h4);
    check("start_pc2", pop_pc_log[2], 32'h8);
    check("start_cyc0", pop_cyc_log[0], 2);
    check("start_cyc1", pop_cyc_log[1], 3);
    check("start_cyc2", pop_cyc_log[2], 4);
    nop_mode = 1'b0;

    // Backpressure: decode stalled for 10 cycles.
    do_reset();
    rdy_pct = 0;
    g0 = grants;
    r0 = req_seen;
    run(10);
    check("bp_grants", grants - g0, 2);
    check("bp_req_cycles", req_seen - r0, 2);
    rdy_pct = 100;
    pop_pc_log.delete();
    run(4);
    check("bp_release_pc0", pop_pc_log[0], 32'h0);
    check("bp_release_pc1", pop_pc_log[1], 32'h4);

    // Redirect while the request for pc 8 is in flight (3-cycle memory).
    do_reset();
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b0, '0);
      found = grant_now && (grant_addr == 32'h8);
    end
    check("inflight_grant_pc8", found, 1);
    pop_pc_log.delete();
    redir(32'h100);
    wait_pop("inflight_next_pc", 32'h100);
    run(4);

    // Redirect together with a response and a decode pop.
    lat_min = 1;
    lat_max = 1;
    run(3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      found = if_valid && pend.size() > 0 && pend[0].ready <= cyc;
      if (!found) cycle(1'b0, '0);
    end
    check("simul_setup", found, 1);
    pop_pc_log.delete();
    redir(32'h300);
    wait_pop("simul_next_pc", 32'h300);

    // Grant asserted in the redirect cycle, with an older request in flight.
    lat_min = 2;
    lat_max = 2;
    run(4);
    pop_pc_log.delete();
    force_gnt = 1'b1;
    redir(32'h400);
    force_gnt = 1'b0;
    wait_pop("gnt_redirect_pc", 32'h400);
    wait_pop("gnt_redirect_pc2", 32'h404);

    // Address wrap.
    lat_min = 1;
    lat_max = 1;
    pop_pc_log.delete();
    redir(32'hFFFF_FFFC);
    wait_pop("wrap_pc0", 32'hFFFF_FFFC);
    wait_pop("wrap_pc1", 32'h0000_0000);

`ifdef IFETCH_MISALIGN_CHECK_EN
    redir(32'h102);
    r0 = req_seen;
    run(6);
    check("mis_no_req", req_seen - r0, 0);
    check("mis_flag", if_misaligned, 1);
    pop_pc_log.delete();
    redir(32'h200);
    check("mis_cleared", if_misaligned, 0);
    wait_pop("mis_resume_pc", 32'h200);
`else
    pop_pc_log.delete();
    redir(32'h102);
    check("align_flag", if_misaligned, 0);
    wait_pop("align_forced_pc", 32'h100);
`endif

    // Randomized traffic with a mid-operation reset.
    gnt_pct = 70;
    rdy_pct = 70;
    lat_min = 1;
    lat_max = 4;
    total_pops = 0;
    for (int i = 0; i < 2500; i++) begin
      logic [31:0] t;
      if (i == 1200) do_reset();
      if ($urandom_range(99) < 3) begin
        t = $urandom;
`ifdef IFETCH_MISALIGN_CHECK_EN
        if ($urandom_range(3) != 0) t[1:0] = 2'b00;
`endif
        cycle(1'b1, t);
      end else begin
        cycle(1'b0, '0);
      end
    end
    check("random_progress", total_pops > 200, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
